// File: rtl/num_class_arb.sv
// num_class_arb
//   Round-robin arbiter that shares one 4-bit number classifier among NREQ
//   requesters. A granted operand is captured, classified in a registered
//   stage, and returned with its requester id on a valid/ready response port.
//   Saturating tallies count delivered prime and divisible-by-3 results.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[NREQ]     requester i holds an operand
//   req_data[4*NREQ]    operand of requester i in bits [4i+3:4i]
//   req_ready[NREQ]     one-hot grant (combinational, only in IDLE)
//   rsp_valid/rsp_ready response handshake
//   rsp_id, rsp_data    source requester and echoed operand
//   rsp_prime, rsp_div3 classification flags
//   clr_cnt             synchronous clear of both tallies
//   prime_cnt, div3_cnt saturating tallies of delivered flags
//   busy                high whenever the sequencer is not idle
module num_class_arb #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [4*NREQ-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [3:0]                rsp_data,
  output logic                      rsp_prime,
  output logic                      rsp_div3,
  input  logic                      clr_cnt,
  output logic [CNT_W-1:0]          prime_cnt,
  output logic [CNT_W-1:0]          div3_cnt,
  output logic                      busy
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  function automatic logic is_prime(input logic [3:0] v);
    case (v)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: is_prime = 1'b1;
      default:                              is_prime = 1'b0;
    endcase
  endfunction

  function automatic logic is_div3(input logic [3:0] v);
    case (v)
      4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: is_div3 = 1'b1;
      default:                              is_div3 = 1'b0;
    endcase
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic en);
    if (en && (c != {CNT_W{1'b1}})) sat_inc = c + CNT_W'(1);
    else                            sat_inc = c;
  endfunction

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_p0;
  logic [3:0]        opnd_p0;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id;
  logic [3:0]        gnt_data;
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   nxt_ptr;
  logic              xfer;
  logic              rsp_hs;

  // Search upward from rr_ptr, wrapping, for the first pending request.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_data  = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == ID_W'(k)) gnt_data = req_data[4*k +: 4];
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state == IDLE) && gnt_found) req_ready[gnt_id] = 1'b1;
  end

  assign xfer    = |(req_valid & req_ready);
  assign rsp_hs  = rsp_valid & rsp_ready;
  assign nxt_ptr = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_p0     <= '0;
      opnd_p0   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_prime <= 1'b0;
      rsp_div3  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        // p0: capture the granted operand and its source
        IDLE: begin
          if (xfer) begin
            id_p0   <= gnt_id;
            opnd_p0 <= gnt_data;
            rr_ptr  <= nxt_ptr;
            busy    <= 1'b1;
            state   <= EVAL;
          end
        end
        // p1: classify and present the response registers
        EVAL: begin
          rsp_id    <= id_p0;
          rsp_data  <= opnd_p0;
          rsp_prime <= is_prime(opnd_p0);
          rsp_div3  <= is_div3(opnd_p0);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Tallies: clear wins over a coincident handshake increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt <= '0;
      div3_cnt  <= '0;
    end else if (clr_cnt) begin
      prime_cnt <= '0;
      div3_cnt  <= '0;
    end else if (rsp_hs) begin
      prime_cnt <= sat_inc(prime_cnt, rsp_prime);
      div3_cnt  <= sat_inc(div3_cnt, rsp_div3);
    end
  end

endmodule
